sp_ram_ctrl: RTL

Parametrised synchronous single-port RAM core with a request handshake, per-byte write enables, self-clearing initialisation, and an optional output pipeline register. It replaces the fixed 4-bit-address, 8-bit-data RAM core behind the chip pad ring. Read data and its output-enable go straight to the bidirectional data pads, with `data_oe` driving the pad OEN through an inverter. Scalable to wider words and deeper arrays without touching the pad-ring wrapper logic.

---
 rtl/sp_ram_pkg.sv | 19 +
 rtl/sp_ram_array.sv | 73 +++++++
 rtl/sp_ram_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the sp_ram_ctrl single-port RAM core.
// The parity feature is selected by the SP_RAM_PARITY_EN macro in the RTL files.
package sp_ram_pkg;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    function automatic int unsigned calc_nbytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Even parity: the stored bit makes the total count of ones in byte+bit even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Word storage with a byte-masked write port and a registered read port.
// With SP_RAM_PARITY_EN defined, one parity bit per byte is stored alongside.
module sp_ram_array
    import sp_ram_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 4,
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned SIZE      = 16,
    localparam int unsigned NBYTES   = calc_nbytes(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [NBYTES-1:0]    be,
`ifdef SP_RAM_PARITY_EN
    input  logic [NBYTES-1:0]    wpar,
    output logic [NBYTES-1:0]    rpar,
`endif
    output logic [DATAWIDTH-1:0] rdata
);

    localparam logic [ADDRWIDTH:0] SizeLim = (ADDRWIDTH + 1)'(SIZE);

    logic [DATAWIDTH-1:0] mem [SIZE];
    logic                 in_range;

    // Addresses at or beyond SIZE never touch storage and read back as zero.
    assign in_range = ({1'b0, addr} < SizeLim);

    always_ff @(posedge clk) begin
        if (wr_en && in_range) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= in_range ? mem[addr] : '0;
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic [NBYTES-1:0] par_mem [SIZE];

    always_ff @(posedge clk) begin
        if (wr_en && in_range) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (be[i]) begin
                    par_mem[addr][i] <= wpar[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpar <= '0;
        end else if (rd_en) begin
            rpar <= in_range ? par_mem[addr] : '0;
        end
    end
`endif

endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM core: init-clear FSM, request accept, optional output register, pad OE.
// Define SP_RAM_PARITY_EN to build per-byte parity storage and checking.
module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 4,
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned SIZE      = 16,
    parameter bit          OUT_REG   = 1'b0,
    localparam int unsigned NBYTES   = calc_nbytes(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [NBYTES-1:0]    be,
    input  logic                 perr_inject,
    output logic                 ready,
    output logic                 init_done,
    output logic                 rsp_valid,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 data_oe,
    output logic                 perr
);

    localparam logic [ADDRWIDTH-1:0] LastAddr = ADDRWIDTH'(SIZE - 1);

    state_e               state_q, state_d;
    logic [ADDRWIDTH-1:0] clr_cnt_q, clr_cnt_d;

    logic                 arr_wr_en;
    logic                 arr_rd_en;
    logic [ADDRWIDTH-1:0] arr_addr;
    logic [DATAWIDTH-1:0] arr_wdata;
    logic [NBYTES-1:0]    arr_be;
    logic [DATAWIDTH-1:0] arr_rdata;

    logic                 wr_acc;
    logic                 rd_acc_q;
    logic                 rsp_next;
    logic                 rd_perr;
    logic                 data_oe_q;

    assign ready     = (state_q == StRun);
    assign init_done = (state_q == StRun);
    assign wr_acc    = ready & cs & we;
    assign data_oe   = data_oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StInit;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // INIT owns the array port to clear one word per cycle; RUN hands it to the requester.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        arr_wr_en = 1'b0;
        arr_rd_en = 1'b0;
        arr_addr  = addr;
        arr_wdata = wdata;
        arr_be    = be;
        unique case (state_q)
            StInit: begin
                arr_wr_en = 1'b1;
                arr_addr  = clr_cnt_q;
                arr_wdata = '0;
                arr_be    = '1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LastAddr) begin
                    state_d   = StRun;
                    clr_cnt_d = '0;
                end
            end
            StRun: begin
                arr_wr_en = cs & we;
                arr_rd_en = cs & ~we;
            end
            default: state_d = StInit;
        endcase
    end

`ifdef SP_RAM_PARITY_EN
    logic [NBYTES-1:0] wr_par;
    logic [NBYTES-1:0] arr_wpar;
    logic [NBYTES-1:0] arr_rpar;

    always_comb begin
        wr_par = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            wr_par[i] = byte_parity(wdata[8*i +: 8]) ^ perr_inject;
        end
    end

    // Cleared words carry parity 0, which is correct for an all-zero byte.
    assign arr_wpar = (state_q == StRun) ? wr_par : '0;

    always_comb begin
        rd_perr = 1'b0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            rd_perr = rd_perr | (byte_parity(arr_rdata[8*i +: 8]) ^ arr_rpar[i]);
        end
    end

    sp_ram_array #(
        .ADDRWIDTH (ADDRWIDTH),
        .DATAWIDTH (DATAWIDTH),
        .SIZE      (SIZE)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (arr_wr_en),
        .rd_en (arr_rd_en),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .be    (arr_be),
        .wpar  (arr_wpar),
        .rpar  (arr_rpar),
        .rdata (arr_rdata)
    );
`else
    logic unused_perr_inject;

    assign unused_perr_inject = perr_inject;
    assign rd_perr            = 1'b0;

    sp_ram_array #(
        .ADDRWIDTH (ADDRWIDTH),
        .DATAWIDTH (DATAWIDTH),
        .SIZE      (SIZE)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (arr_wr_en),
        .rd_en (arr_rd_en),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .be    (arr_be),
        .rdata (arr_rdata)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_acc_q <= 1'b0;
        end else begin
            rd_acc_q <= arr_rd_en;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic                 rsp_valid_q;
        logic [DATAWIDTH-1:0] rdata_q;
        logic                 perr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rsp_valid_q <= 1'b0;
                rdata_q     <= '0;
                perr_q      <= 1'b0;
            end else begin
                rsp_valid_q <= rd_acc_q;
                if (rd_acc_q) begin
                    rdata_q <= arr_rdata;
                    perr_q  <= rd_perr;
                end
            end
        end

        assign rsp_valid = rsp_valid_q;
        assign rdata     = rdata_q;
        assign perr      = perr_q;
        assign rsp_next  = rd_acc_q;
    end else begin : g_no_out_reg
        // The array read register already holds data between responses.
        assign rsp_valid = rd_acc_q;
        assign rdata     = arr_rdata;
        assign perr      = rd_perr;
        assign rsp_next  = arr_rd_en;
    end

    // A response arriving on the same edge as a write wins, so data_oe is always high with rsp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_oe_q <= 1'b0;
        end else if (rsp_next) begin
            data_oe_q <= 1'b1;
        end else if (wr_acc) begin
            data_oe_q <= 1'b0;
        end
    end

endmodule
